led_mode_ctrl: RTL and testbench



---
 rtl/led_mode_ctrl.sv | 74 +++++++
 tb/tb_led_mode_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: four-mode LED sequencer (off, breathing, blink, chase) with pause/hold
module led_mode_ctrl #(
  parameter int BLINK_HALF = 500000,
  parameter int STEP_CNT   = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next,
  input  logic       key_pause,
  input  logic [7:0] breath_led,
  output logic       en_breath,
  output logic [7:0] led,
  output logic [1:0] mode
);
  localparam int BW = $clog2(BLINK_HALF > 1 ? BLINK_HALF : 2);
  localparam int SW = $clog2(STEP_CNT > 1 ? STEP_CNT : 2);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_HALF - 1);
  localparam logic [SW-1:0] STEP_TC = SW'(STEP_CNT - 1);
  typedef enum logic [1:0] {OFF, BREATH, BLINK, CHASE} mode_t;
  mode_t mode_q, mode_d;
  logic paused_q, paused_d, phase_q, phase_d, blink_tc, step_tc;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [7:0] pattern_q, pattern_d, led_q, led_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= OFF;
      paused_q    <= 1'b0;
      phase_q     <= 1'b0;
      blink_cnt_q <= '0;
      step_cnt_q  <= '0;
      pattern_q   <= 8'h01;
      led_q       <= 8'h00;
    end else begin
      mode_q      <= mode_d;
      paused_q    <= paused_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      step_cnt_q  <= step_cnt_d;
      pattern_q   <= pattern_d;
      led_q       <= led_d;
    end
  end
  always_comb begin
    mode_d      = key_next ? mode_t'(mode_q + 2'd1) : mode_q;
    paused_d    = !key_next && ((key_pause && mode_q != OFF) ? !paused_q : paused_q);
    blink_tc    = blink_cnt_q == BLINK_TC;
    step_tc     = step_cnt_q == STEP_TC;
    blink_cnt_d = blink_cnt_q;
    step_cnt_d  = step_cnt_q;
    phase_d     = phase_q;
    pattern_d   = pattern_q;
    // a mode change loads the entry state of whichever mode comes next
    if (key_next) begin
      blink_cnt_d = '0;
      step_cnt_d  = '0;
      phase_d     = mode_d == BLINK;
      pattern_d   = 8'h01;
    end else if (!paused_q && mode_q == BLINK) begin
      blink_cnt_d = blink_tc ? '0 : blink_cnt_q + 1'b1;
      phase_d     = phase_q ^ blink_tc;
    end else if (!paused_q && mode_q == CHASE) begin
      step_cnt_d = step_tc ? '0 : step_cnt_q + 1'b1;
      pattern_d  = step_tc ? {pattern_q[6:0], pattern_q[7]} : pattern_q;
    end
    led_d = paused_q ? led_q :
            mode_q == BREATH ? breath_led :
            mode_q == BLINK ? {8{phase_q}} :
            mode_q == CHASE ? pattern_q : 8'h00;
  end
  assign mode      = mode_q;
  assign en_breath = mode_q == BREATH && !paused_q;
  assign led       = led_q;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: scoreboard bench for led_mode_ctrl with BLINK_HALF=4, STEP_CNT=3
module tb_led_mode_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, key_next = 1'b0, key_pause = 1'b0;
  logic [7:0] breath_led = 8'h00, led;
  logic [1:0] mode;
  logic en_breath;
  int checks = 0, failures = 0;
  logic [10:0] sb[$];
  logic [10:0] e;
  led_mode_ctrl #(.BLINK_HALF(4), .STEP_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_next(key_next), .key_pause(key_pause),
    .breath_led(breath_led), .en_breath(en_breath), .led(led), .mode(mode)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input logic kn, input logic kp, input logic [7:0] bl, input logic [10:0] exp);
    key_next = kn;
    key_pause = kp;
    breath_led = bl;
    sb.push_back(exp);
    step();
    key_next = 1'b0;
    key_pause = 1'b0;
  endtask
  task automatic test_reset();
    logic [10:0] e1 [4] = '{{8'h00, 2'd1, 1'b1}, {8'h3C, 2'd2, 1'b0}, {8'hFF, 2'd3, 1'b0}, {8'h08, 2'd0, 1'b0}};
    logic [10:0] e2 [4] = '{{8'h3C, 2'd1, 1'b1}, {8'hFF, 2'd2, 1'b0}, {8'h04, 2'd3, 1'b0}, {8'h00, 2'd0, 1'b0}};
    rst_n = 1'b0;
    breath_led = 8'h3C;
    repeat (3) step();
    rst_n = 1'b1;
    sb.push_back({8'h00, 2'd0, 1'b0});
    e = sb.pop_front();
    checks++;
    if ({led, mode, en_breath} !== e) begin
      failures++;
      $display("FAIL reset got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", led, mode, en_breath, e[10:3], e[2:1], e[0]);
    end
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, 8'h3C, e1[k]);
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL cycle_pulse%0d got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
      repeat (8) step();
      apply(1'b0, 1'b0, 8'h3C, e2[k]);
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL cycle_settle%0d got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
    end
  endtask
  task automatic test_blink();
    apply(1'b1, 1'b0, 8'h00, {8'h00, 2'd1, 1'b1});
    void'(sb.pop_front());
    for (int k = 0; k < 17; k++) begin
      apply(k == 0, 1'b0, 8'h00, {(k == 0) ? 8'h00 : (((k - 1) / 4) % 2 == 0 ? 8'hFF : 8'h00), 2'd2, 1'b0});
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL blink[%0d] got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
    end
  endtask
  task automatic test_chase();
    for (int k = 0; k < 28; k++) begin
      apply(k == 0, 1'b0, 8'h00, {(k == 0) ? 8'hFF : 8'(1 << (((k - 1) / 3) % 8)), 2'd3, 1'b0});
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL chase[%0d] got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
    end
  endtask
  task automatic test_pause_chase();
    logic [7:0] resume [7] = '{8'h04, 8'h04, 8'h04, 8'h08, 8'h08, 8'h08, 8'h10};
    repeat (3) step();
    for (int k = 0; k < 21; k++) begin
      apply(1'b0, k == 0, 8'h00, {8'h04, 2'd3, 1'b0});
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL pause_hold[%0d] got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
    end
    for (int k = 0; k < 7; k++) begin
      apply(1'b0, k == 0, 8'h00, {resume[k], 2'd3, 1'b0});
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL pause_resume[%0d] got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
    end
  endtask
  task automatic test_breath();
    logic [20:0] rows [13] = '{
      {1'b1, 1'b0, 8'hA5, 8'h10, 2'd0, 1'b0},
      {1'b1, 1'b0, 8'hA5, 8'h00, 2'd1, 1'b1},
      {1'b0, 1'b0, 8'hA5, 8'hA5, 2'd1, 1'b1},
      {1'b0, 1'b0, 8'h5A, 8'h5A, 2'd1, 1'b1},
      {1'b0, 1'b1, 8'h5A, 8'h5A, 2'd1, 1'b0},
      {1'b0, 1'b0, 8'hFF, 8'h5A, 2'd1, 1'b0},
      {1'b0, 1'b0, 8'hFF, 8'h5A, 2'd1, 1'b0},
      {1'b1, 1'b1, 8'hFF, 8'h5A, 2'd2, 1'b0},
      {1'b0, 1'b0, 8'hFF, 8'hFF, 2'd2, 1'b0},
      {1'b0, 1'b0, 8'hFF, 8'hFF, 2'd2, 1'b0},
      {1'b0, 1'b0, 8'hFF, 8'hFF, 2'd2, 1'b0},
      {1'b0, 1'b0, 8'hFF, 8'hFF, 2'd2, 1'b0},
      {1'b0, 1'b0, 8'hFF, 8'h00, 2'd2, 1'b0}
    };
    for (int k = 0; k < 13; k++) begin
      apply(rows[k][20], rows[k][19], rows[k][18:11], rows[k][10:0]);
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL breath[%0d] got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
    end
  endtask
  task automatic test_reset_mid_blink();
    logic [10:0] exp [8] = '{{8'h00, 2'd2, 1'b0}, {8'h00, 2'd2, 1'b0}, {8'h00, 2'd2, 1'b0},
                             {8'h00, 2'd0, 1'b0}, {8'h00, 2'd0, 1'b0}, {8'h00, 2'd1, 1'b1},
                             {8'hFF, 2'd1, 1'b1}, {8'hFF, 2'd1, 1'b1}};
    for (int k = 0; k < 8; k++) begin
      rst_n = !(k == 3);
      apply(k == 3 || k == 5, 1'b0, 8'hFF, exp[k]);
      rst_n = 1'b1;
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL reset_mid[%0d] got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [10:0] exp [3] = '{{8'h11, 2'd2, 1'b0}, {8'hFF, 2'd3, 1'b0}, {8'h01, 2'd3, 1'b0}};
    for (int k = 0; k < 3; k++) begin
      apply(k < 2, 1'b0, 8'h11, exp[k]);
      e = sb.pop_front();
      checks++;
      if ({led, mode, en_breath} !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d] got led=%h mode=%0d en=%b exp led=%h mode=%0d en=%b", k, led, mode, en_breath, e[10:3], e[2:1], e[0]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_blink();
    test_chase();
    test_pause_chase();
    test_breath();
    test_reset_mid_blink();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
